// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly (out1 = A + W*B, out2 = A - W*B) with /2 scaling,
// saturation and a sticky overflow flag. Define BFLY_ROUND_EN for round-half-up instead of truncation.
module butterfly_pipe #(
   parameter int DW      = 16,
   parameter int TW_FRAC = DW-1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] a,
   input  logic [2*DW-1:0] b,
   input  logic [2*DW-1:0] w,
   input  logic            scale,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] out1,
   output logic [2*DW-1:0] out2,
   output logic            ovf,
   input  logic            ovf_clr
);
   localparam int PW = 2*DW;
   localparam int TW = DW+2;

`ifdef BFLY_ROUND_EN
   localparam logic [PW:0]   RND_T = {{PW{1'b0}}, 1'b1} << (TW_FRAC-1);
   localparam logic [TW-1:0] RND_S = {{(TW-1){1'b0}}, 1'b1};
`else
   localparam logic [PW:0]   RND_T = '0;
   localparam logic [TW-1:0] RND_S = '0;
`endif

   // Handshake: a beat moves on valid & ready; every stage shifts together when w_adv is high.
   logic w_adv;

   logic signed [DW-1:0] w_br, w_bi, w_wr, w_wi;
   logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
   logic [PW-1:0]        r_p_rr, r_p_ii, r_p_ri, r_p_ir;
   logic [PW-1:0]        r_a1, r_a2;
   logic                 r_sc1, r_sc2;
   logic                 r_v1, r_v2, r_v3;

   logic [PW:0]          w_tr_full, w_ti_full;
   logic [TW-1:0]        w_tr_sh, w_ti_sh;
   logic [TW-1:0]        r_tr, r_ti;

   logic [TW-1:0]        w_ar, w_ai;
   logic [TW-1:0]        w_sum  [4];
   logic [TW-1:0]        w_rs   [4];
   logic [TW-1:0]        w_half [4];
   logic [TW-1:0]        w_sc   [4];
   logic [DW-1:0]        w_sat  [4];
   logic [3:0]           w_clamp;

   logic [PW-1:0]        r_out1, r_out2;
   logic                 r_ovf;

   assign w_adv    = out_ready | ~r_v3;
   assign in_ready = w_adv;

   assign w_br = b[PW-1:DW];
   assign w_bi = b[DW-1:0];
   assign w_wr = w[PW-1:DW];
   assign w_wi = w[DW-1:0];

   assign w_p_rr = PW'(w_br) * PW'(w_wr);
   assign w_p_ii = PW'(w_bi) * PW'(w_wi);
   assign w_p_ri = PW'(w_br) * PW'(w_wi);
   assign w_p_ir = PW'(w_bi) * PW'(w_wr);

   // One guard bit keeps the -1 * -1 corner exact before the twiddle shift.
   assign w_tr_full = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii} + RND_T;
   assign w_ti_full = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir} + RND_T;
   assign w_tr_sh   = TW'($signed(w_tr_full) >>> TW_FRAC);
   assign w_ti_sh   = TW'($signed(w_ti_full) >>> TW_FRAC);

   assign w_ar     = {{2{r_a2[PW-1]}}, r_a2[PW-1:DW]};
   assign w_ai     = {{2{r_a2[DW-1]}}, r_a2[DW-1:0]};
   assign w_sum[0] = w_ar + r_tr;
   assign w_sum[1] = w_ai + r_ti;
   assign w_sum[2] = w_ar - r_tr;
   assign w_sum[3] = w_ai - r_ti;

   always_comb begin
      w_rs    = '{default: '0};
      w_half  = '{default: '0};
      w_sc    = '{default: '0};
      w_sat   = '{default: '0};
      w_clamp = '0;
      for (int i = 0; i < 4; i++) begin
         w_rs[i]   = w_sum[i] + RND_S;
         w_half[i] = $signed(w_rs[i]) >>> 1;
         w_sc[i]   = r_sc2 ? w_half[i] : w_sum[i];
         // In range only when the top three bits are all equal.
         w_clamp[i] = ~((&w_sc[i][TW-1:DW-1]) | ~(|w_sc[i][TW-1:DW-1]));
         if (w_clamp[i])
            w_sat[i] = w_sc[i][TW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         else
            w_sat[i] = w_sc[i][DW-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_p_rr <= '0;
         r_p_ii <= '0;
         r_p_ri <= '0;
         r_p_ir <= '0;
         r_a1   <= '0;
         r_a2   <= '0;
         r_sc1  <= 1'b0;
         r_sc2  <= 1'b0;
         r_tr   <= '0;
         r_ti   <= '0;
         r_out1 <= '0;
         r_out2 <= '0;
      end else if (w_adv) begin
         r_v1   <= in_valid;
         r_p_rr <= w_p_rr;
         r_p_ii <= w_p_ii;
         r_p_ri <= w_p_ri;
         r_p_ir <= w_p_ir;
         r_a1   <= a;
         r_sc1  <= scale;
         r_v2   <= r_v1;
         r_tr   <= w_tr_sh;
         r_ti   <= w_ti_sh;
         r_a2   <= r_a1;
         r_sc2  <= r_sc1;
         r_v3   <= r_v2;
         r_out1 <= {w_sat[0], w_sat[1]};
         r_out2 <= {w_sat[2], w_sat[3]};
      end
   end

   // Set beats clear when both happen on the same edge; a held output never re-sets it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_ovf <= 1'b0;
      else if (w_adv & r_v2 & (|w_clamp))
         r_ovf <= 1'b1;
      else if (ovf_clr)
         r_ovf <= 1'b0;
   end

   assign out_valid = r_v3;
   assign out1      = r_out1;
   assign out2      = r_out2;
   assign ovf       = r_ovf;
endmodule
